// File: rtl/reg_fifo_n_if.sv
// ============================================================================
// Module      : reg_fifo_n_if
// Description : Write/read/status bundle for the reg_fifo_n register FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface reg_fifo_n_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH + 1)
);
   logic             iWrEn;
   logic [WIDTH-1:0] iWrDat;
   logic             iRdEn;
   logic             iErrClr;
   logic             oFul;
   logic             oEmpty;
   logic             oAlmFul;
   logic [CW-1:0]    oCnt;
   logic [WIDTH-1:0] oRdDat;
   logic             oOvf;
   logic             oUdf;

   modport master (
      output iWrEn, iWrDat, iRdEn, iErrClr,
      input  oFul, oEmpty, oAlmFul, oCnt, oRdDat, oOvf, oUdf
   );

   modport slave (
      input  iWrEn, iWrDat, iRdEn, iErrClr,
      output oFul, oEmpty, oAlmFul, oCnt, oRdDat, oOvf, oUdf
   );
endinterface

`default_nettype wire

// File: rtl/reg_fifo_n.sv
// ============================================================================
// Module      : reg_fifo_n
// Description : Register-based FWFT FIFO with occupancy, almost-full and
//               sticky overflow/underflow flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_fifo_n #(
   parameter int WIDTH  = 8,
   parameter int DEPTH  = 4,
   parameter int AF_LVL = DEPTH - 1
) (
   input  wire logic   clk,
   input  wire logic   rst,
   reg_fifo_n_if.slave bus
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);

   localparam logic [PW-1:0] c_PTR_LAST = PW'(DEPTH - 1);
   localparam logic [CW-1:0] c_DEPTH    = CW'(DEPTH);
   localparam logic [CW-1:0] c_AF_LVL   = CW'(AF_LVL);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_cnt;
   logic             r_ovf;
   logic             r_udf;

   logic             w_full;
   logic             w_empty;
   logic             w_rd_acc;
   logic             w_wr_acc;
   logic             w_ovf_set;
   logic             w_udf_set;

   // Explicit wrap so non-power-of-two depths never index past the array.
   function automatic logic [PW-1:0] f_ptr_inc(input logic [PW-1:0] p);
      return (p == c_PTR_LAST) ? '0 : p + PW'(1);
   endfunction

   assign w_full    = (r_cnt == c_DEPTH);
   assign w_empty   = (r_cnt == '0);
   assign w_rd_acc  = bus.iRdEn & ~w_empty;
   assign w_wr_acc  = bus.iWrEn & (~w_full | w_rd_acc);
   assign w_ovf_set = bus.iWrEn & ~w_wr_acc;
   assign w_udf_set = bus.iRdEn & ~w_rd_acc;

   always_ff @(posedge clk) begin
      if (w_wr_acc) begin
         r_mem[r_wr_ptr] <= bus.iWrDat;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
         r_ovf    <= 1'b0;
         r_udf    <= 1'b0;
      end else begin
         if (w_wr_acc) begin
            r_wr_ptr <= f_ptr_inc(r_wr_ptr);
         end
         if (w_rd_acc) begin
            r_rd_ptr <= f_ptr_inc(r_rd_ptr);
         end
         case ({w_wr_acc, w_rd_acc})
            2'b10:   r_cnt <= r_cnt + CW'(1);
            2'b01:   r_cnt <= r_cnt - CW'(1);
            default: r_cnt <= r_cnt;
         endcase
         // A new error in the clearing cycle takes precedence.
         r_ovf <= w_ovf_set | (r_ovf & ~bus.iErrClr);
         r_udf <= w_udf_set | (r_udf & ~bus.iErrClr);
      end
   end

   assign bus.oFul    = w_full;
   assign bus.oEmpty  = w_empty;
   assign bus.oAlmFul = (r_cnt >= c_AF_LVL);
   assign bus.oCnt    = r_cnt;
   assign bus.oRdDat  = w_empty ? '0 : r_mem[r_rd_ptr];
   assign bus.oOvf    = r_ovf;
   assign bus.oUdf    = r_udf;

endmodule

`default_nettype wire

// File: tb/tb_reg_fifo_n.sv
// ============================================================================
// Module      : tb_reg_fifo_n
// Description : Self-checking bench for reg_fifo_n at DEPTH=4 and DEPTH=3.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_fifo_n;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   reg_fifo_n_if #(.WIDTH(8), .DEPTH(4)) b4 ();
   reg_fifo_n_if #(.WIDTH(8), .DEPTH(3)) b3 ();

   reg_fifo_n #(.WIDTH(8), .DEPTH(4), .AF_LVL(3)) u_dut4 (.clk(clk), .rst(rst), .bus(b4));
   reg_fifo_n #(.WIDTH(8), .DEPTH(3), .AF_LVL(2)) u_dut3 (.clk(clk), .rst(rst), .bus(b3));

   int nchk = 0;
   int nerr = 0;
   int cur  = 0;

   typedef struct {
      logic       wr, rd, clr;
      logic [7:0] dat;
      logic [2:0] cnt;
      logic [7:0] rdat;
      logic       ful, emp, af, ovf, udf;
   } vec_t;
   vec_t tbl [17];

   logic [7:0] mq [$];
   logic       m_ovf, m_udf;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic drive(logic wr, logic rd, logic clr, logic [7:0] d);
      b4.iWrEn = 1'b0; b4.iRdEn = 1'b0; b4.iErrClr = 1'b0; b4.iWrDat = 8'h00;
      b3.iWrEn = 1'b0; b3.iRdEn = 1'b0; b3.iErrClr = 1'b0; b3.iWrDat = 8'h00;
      if (cur == 0) begin
         b4.iWrEn = wr; b4.iRdEn = rd; b4.iErrClr = clr; b4.iWrDat = d;
      end else begin
         b3.iWrEn = wr; b3.iRdEn = rd; b3.iErrClr = clr; b3.iWrDat = d;
      end
   endtask

   task automatic check_outs(string tag, logic [2:0] cnt, logic [7:0] rdat,
                             logic ful, logic emp, logic af, logic ovf, logic udf);
      if (cur == 0) begin
         chk({tag, " cnt"},   32'(b4.oCnt),    32'(cnt));
         chk({tag, " rdat"},  32'(b4.oRdDat),  32'(rdat));
         chk({tag, " ful"},   32'(b4.oFul),    32'(ful));
         chk({tag, " empty"}, 32'(b4.oEmpty),  32'(emp));
         chk({tag, " almful"},32'(b4.oAlmFul), 32'(af));
         chk({tag, " ovf"},   32'(b4.oOvf),    32'(ovf));
         chk({tag, " udf"},   32'(b4.oUdf),    32'(udf));
      end else begin
         chk({tag, " cnt"},   32'(b3.oCnt),    32'(cnt));
         chk({tag, " rdat"},  32'(b3.oRdDat),  32'(rdat));
         chk({tag, " ful"},   32'(b3.oFul),    32'(ful));
         chk({tag, " empty"}, 32'(b3.oEmpty),  32'(emp));
         chk({tag, " almful"},32'(b3.oAlmFul), 32'(af));
         chk({tag, " ovf"},   32'(b3.oOvf),    32'(ovf));
         chk({tag, " udf"},   32'(b3.oUdf),    32'(udf));
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
   endtask

   // Queue-level behaviour: pop happens before push so write-through-full works.
   task automatic model_step(logic wr, logic rd, logic clr, logic [7:0] d, int depth);
      bit racc, wacc;
      racc = rd && (mq.size() > 0);
      wacc = wr && ((mq.size() < depth) || racc);
      if (racc) void'(mq.pop_front());
      if (wacc) mq.push_back(d);
      m_ovf = (wr && !wacc) ? 1'b1 : (clr ? 1'b0 : m_ovf);
      m_udf = (rd && !racc) ? 1'b1 : (clr ? 1'b0 : m_udf);
   endtask

   task automatic check_model(string tag, int depth, int af);
      int n;
      n = mq.size();
      check_outs(tag, 3'(n), (n > 0) ? mq[0] : 8'h00, n == depth, n == 0,
                 n >= af, m_ovf, m_udf);
   endtask

   task automatic setv(int i, logic wr, logic rd, logic clr, logic [7:0] d,
                       logic [2:0] cnt, logic [7:0] rdat,
                       logic ful, logic emp, logic af, logic ovf, logic udf);
      tbl[i].wr = wr; tbl[i].rd = rd; tbl[i].clr = clr; tbl[i].dat = d;
      tbl[i].cnt = cnt; tbl[i].rdat = rdat; tbl[i].ful = ful; tbl[i].emp = emp;
      tbl[i].af = af; tbl[i].ovf = ovf; tbl[i].udf = udf;
   endtask

   task automatic random_run(int depth, int af, int cycles);
      logic wr, rd, clr;
      logic [7:0] d;
      for (int i = 0; i < cycles; i++) begin
         wr  = ($urandom_range(0, 99) < 60);
         rd  = ($urandom_range(0, 99) < 50);
         clr = ($urandom_range(0, 99) < 10);
         d   = 8'($urandom_range(0, 255));
         drive(wr, rd, clr, d);
         model_step(wr, rd, clr, d, depth);
         tick();
         check_model($sformatf("rand d%0d c%0d", depth, i), depth, af);
      end
   endtask

   initial begin
      rst = 1'b1;
      cur = 0;
      drive(1'b0, 1'b0, 1'b0, 8'h00);
      tick();
      check_outs("reset", 3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      tick();

      //      wr    rd    clr   dat    cnt   rdat   ful   emp   af    ovf   udf
      setv(0,  1'b1, 1'b0, 1'b0, 8'h01, 3'd1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      setv(1,  1'b1, 1'b0, 1'b0, 8'h02, 3'd2, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      setv(2,  1'b1, 1'b0, 1'b0, 8'h03, 3'd3, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      setv(3,  1'b1, 1'b0, 1'b0, 8'h04, 3'd4, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      setv(4,  1'b1, 1'b0, 1'b0, 8'h05, 3'd4, 8'h01, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      setv(5,  1'b0, 1'b0, 1'b1, 8'h00, 3'd4, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      setv(6,  1'b1, 1'b1, 1'b0, 8'h05, 3'd4, 8'h02, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      setv(7,  1'b0, 1'b1, 1'b0, 8'h00, 3'd3, 8'h03, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      setv(8,  1'b0, 1'b1, 1'b0, 8'h00, 3'd2, 8'h04, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      setv(9,  1'b0, 1'b1, 1'b0, 8'h00, 3'd1, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      setv(10, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      setv(11, 1'b1, 1'b1, 1'b0, 8'hAA, 3'd1, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      setv(12, 1'b0, 1'b0, 1'b1, 8'h00, 3'd1, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      setv(13, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      setv(14, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      setv(15, 1'b0, 1'b1, 1'b1, 8'h00, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      setv(16, 1'b0, 1'b0, 1'b1, 8'h00, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < 17; i++) begin
         drive(tbl[i].wr, tbl[i].rd, tbl[i].clr, tbl[i].dat);
         tick();
         check_outs($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].rdat, tbl[i].ful,
                    tbl[i].emp, tbl[i].af, tbl[i].ovf, tbl[i].udf);
      end

      // Reset mid-operation: three entries plus a sticky flag, pulse rst mid-cycle.
      drive(1'b0, 1'b1, 1'b0, 8'h00); tick();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, 1'b0, 8'(8'h20 + i)); tick();
      end
      check_outs("pre-rst", 3'd3, 8'h20, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 8'h00);
      #3 rst = 1'b1;
      #1;
      check_outs("async-rst", 3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      rst = 1'b0;
      drive(1'b1, 1'b0, 1'b0, 8'h55); tick();
      check_outs("post-rst wr", 3'd1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 1'b0, 8'h00); tick();
      check_outs("post-rst rd", 3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

      // Wrap on the depth-3 instance: steady write+read after one priming word.
      cur = 1;
      drive(1'b1, 1'b0, 1'b0, 8'h0F); tick();
      check_outs("wrap prime", 3'd1, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 1'b1, 1'b0, 8'(8'h10 + i)); tick();
         check_outs($sformatf("wrap%0d", i), 3'd1, 8'(8'h10 + i),
                    1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      drive(1'b0, 1'b1, 1'b0, 8'h00); tick();
      check_outs("wrap drain", 3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

      // Randomised traffic against the queue model on both depths.
      cur = 0;
      drive(1'b0, 1'b0, 1'b0, 8'h00);
      rst = 1'b1; tick(); rst = 1'b0;
      model_reset();
      random_run(4, 3, 400);

      cur = 1;
      drive(1'b0, 1'b0, 1'b0, 8'h00);
      rst = 1'b1; tick(); rst = 1'b0;
      model_reset();
      random_run(3, 2, 400);

      drive(1'b0, 1'b0, 1'b0, 8'h00);
      tick();
      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/reg_fifo_n.md
Name: reg_fifo_n

Overview:
Parametrised register-based synchronous FIFO. It is the next generation of the two-entry ring-stop buffer, generalised to any width and depth. It adds an occupancy count, a programmable almost-full threshold, write-through-when-full, and sticky overflow/underflow error flags. It is instantiated in ring-stop ingress/egress paths wherever more than two flits of elasticity are needed, and in credit return paths where backpressure must be raised early via almost-full.

Parameters:
WIDTH, 8, data width in bits (>=1)
DEPTH, 4, number of entries (>=2; power of two not required)
AF_LVL, DEPTH-1, oAlmFul asserts when occupancy >= AF_LVL (1..DEPTH)
CW, $clog2(DEPTH+1), occupancy counter width (derived, not overridden)

Ports:
clk     input   1      clock, all state on rising edge
rst     input   1      reset, asynchronous, active-high
iWrEn   input   1      write request
iWrDat  input   WIDTH  write data
iRdEn   input   1      read request (pops head entry)
iErrClr input   1      synchronous clear of oOvf/oUdf
oFul    output  1      occupancy == DEPTH
oEmpty  output  1      occupancy == 0
oAlmFul output  1      occupancy >= AF_LVL
oCnt    output  CW     current occupancy 0..DEPTH
oRdDat  output  WIDTH  head entry, first-word-fall-through
oOvf    output  1      sticky: write rejected
oUdf    output  1      sticky: read rejected

Behaviour:
- Reset (rst high, async): wrPtr=rdPtr=0, oCnt=0, oEmpty=1, oFul=0, oAlmFul=0, oOvf=0, oUdf=0, oRdDat=0. Storage array is not reset.
- All flags are decoded from registered oCnt. No combinational path from iWrEn/iRdEn to any flag.
- oRdDat = mem[rdPtr] when !oEmpty, else 0. Combinational from registers only.
- Read accept: rdAcc = iRdEn & !oEmpty.
- Write accept: wrAcc = iWrEn & (!oFul | rdAcc). Write-when-full succeeds only if a read is accepted in the same cycle.
- Empty with iWrEn & iRdEn: read rejected (oUdf set), write accepted, oCnt 0->1. No bypass: data appears on oRdDat the next cycle.
- Latency: a word written at edge k is visible on oRdDat after edge k if it becomes head; minimum write-to-read latency is 1 cycle.
- Pointers increment on accept and wrap from DEPTH-1 to 0. Non-power-of-two DEPTH must wrap correctly.
- oCnt next value:
  - +1 if wrAcc & !rdAcc
  - -1 if rdAcc & !wrAcc
  - unchanged otherwise
  - never exceeds DEPTH, never underflows.
- Sticky error flags:
  - oOvf set on iWrEn & !wrAcc.
  - oUdf set on iRdEn & !rdAcc.
  - Both cleared by iErrClr. If a set condition and iErrClr occur in the same cycle, set wins.
- Rejected writes do not modify storage or pointers. Rejected reads do not move rdPtr.
- Ordering is strict FIFO; no reordering, duplication or loss of accepted words.
- rst asserted mid-operation discards all contents immediately. The first write after deassertion lands at entry 0.

Test Plan:
(DEPTH=4, WIDTH=8, AF_LVL=3 unless noted)
1. Reset then idle: rst pulse mid-cycle -> immediately oEmpty=1, oFul=0, oCnt=0, oRdDat=0, oOvf=oUdf=0.
2. Fill: write 0x01..0x04 on 4 consecutive cycles -> oCnt 1,2,3,4; oAlmFul rises with oCnt=3; oFul=1 after 4th edge; oRdDat=0x01 from cycle after first write. 5th write of 0x05 alone -> rejected, oCnt=4, oOvf=1.
3. Full write-through: full with 0x01..0x04, iWrEn=iRdEn=1 with 0x05 -> oCnt stays 4, oRdDat=0x02; drain 4 reads -> 0x02,0x03,0x04,0x05, then oEmpty=1, oOvf=0.
4. Empty corner: empty, iRdEn=iWrEn=1 with 0xAA -> oCnt=1, oRdDat=0xAA next cycle, oUdf=1; iErrClr=1 -> oUdf=0.
5. Wrap (DEPTH=3, AF_LVL=2): 10 cycles of steady write+read of 0x10..0x19 after priming with one word -> output sequence matches input order, oCnt constant at 1, pointers wrap 3 times with no loss.
6. Reset mid-operation: with oCnt=3, assert rst -> oCnt=0 asynchronously; after release, write 0x55 -> oRdDat=0x55, oCnt=1.
